// File: rtl/core_mem_ctrl.sv
// core_mem_ctrl: memory-phase sequencer for the Selen pipeline.
// Takes the load/store held by the memory stage, issues a single L1D request
// (tagged cacheable/uncacheable), stalls until the acknowledge arrives and then
// releases the stage for one cycle with the load data on mem_rdata.
//
// Handshake: l1d_req_vld is registered and, once raised, stays high with
// addr/wdata/be/we/cash held stable until the cycle in which l1d_req_rdy is
// sampled high; that cycle is the transfer. l1d_ack_vld is a single-cycle
// response with no back-pressure and is only consumed in WAIT and DRAIN.
module core_mem_ctrl #(
   parameter int unsigned TIMEOUT = 255,
   parameter int unsigned CNT_W   = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mem_req_vld,
   input  logic        mem_req_we,
   input  logic [31:0] mem_req_addr,
   input  logic [31:0] mem_req_wdata,
   input  logic [3:0]  mem_req_be,
   input  logic [31:0] mem_cash_base,
   input  logic        mem_flush,
   output logic        l1d_req_vld,
   input  logic        l1d_req_rdy,
   output logic        l1d_req_we,
   output logic [31:0] l1d_req_addr,
   output logic [31:0] l1d_req_wdata,
   output logic [3:0]  l1d_req_be,
   output logic        l1d_req_cash,
   input  logic        l1d_ack_vld,
   input  logic [31:0] l1d_ack_data,
   output logic        mem_stall,
   output logic        mem_enb,
   output logic        mem_kill,
   output logic [31:0] mem_rdata,
   output logic        mem_err
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_REQ   = 3'd1,
      S_WAIT  = 3'd2,
      S_DONE  = 3'd3,
      S_DRAIN = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_inc;
   logic             cnt_expired;
   logic             to_flag;

   // Saturating increment: the counter parks at all-ones instead of wrapping.
   always_comb begin
      cnt_inc     = (cnt == '1) ? cnt : cnt + CNT_ONE;
      cnt_expired = (cnt == CNT_LAST);
   end

   // Access sequencer: state, request payload, load data and error pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= S_IDLE;
         cnt           <= '0;
         to_flag       <= 1'b0;
         l1d_req_vld   <= 1'b0;
         l1d_req_we    <= 1'b0;
         l1d_req_addr  <= '0;
         l1d_req_wdata <= '0;
         l1d_req_be    <= '0;
         l1d_req_cash  <= 1'b0;
         mem_rdata     <= '0;
         mem_err       <= 1'b0;
      end else begin
         mem_err <= 1'b0;
         case (state)
            S_IDLE: begin
               to_flag <= 1'b0;
               if (mem_req_vld && !mem_flush) begin
                  l1d_req_vld   <= 1'b1;
                  l1d_req_we    <= mem_req_we;
                  l1d_req_addr  <= mem_req_addr;
                  l1d_req_wdata <= mem_req_wdata;
                  l1d_req_be    <= mem_req_be;
                  l1d_req_cash  <= (mem_req_addr > mem_cash_base);
                  cnt           <= '0;
                  state         <= S_REQ;
               end
            end
            S_REQ: begin
               if (l1d_req_rdy) begin
                  // Once accepted the ack must be collected, even if flushed.
                  l1d_req_vld <= 1'b0;
                  cnt         <= '0;
                  state       <= mem_flush ? S_DRAIN : S_WAIT;
               end else if (mem_flush) begin
                  l1d_req_vld <= 1'b0;
                  state       <= S_IDLE;
               end else if (cnt_expired) begin
                  l1d_req_vld <= 1'b0;
                  mem_err     <= 1'b1;
                  to_flag     <= 1'b1;
                  state       <= S_DONE;
               end else begin
                  cnt <= cnt_inc;
               end
            end
            S_WAIT: begin
               if (l1d_ack_vld) begin
                  // An ack in the same cycle as a flush closes the access; the
                  // data is dropped since the instruction is being killed.
                  if (mem_flush) begin
                     state <= S_IDLE;
                  end else begin
                     if (!l1d_req_we) mem_rdata <= l1d_ack_data;
                     state <= S_DONE;
                  end
               end else if (mem_flush) begin
                  state <= S_DRAIN;
               end else if (cnt_expired) begin
                  mem_err <= 1'b1;
                  to_flag <= 1'b1;
                  state   <= S_DONE;
               end else begin
                  cnt <= cnt_inc;
               end
            end
            S_DONE: begin
               to_flag <= 1'b0;
               state   <= S_IDLE;
            end
            S_DRAIN: begin
               if (l1d_ack_vld) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Pipeline controls derived from the current state and the stage inputs.
   always_comb begin
      mem_stall = ((state == S_IDLE) && mem_req_vld && !mem_flush) ||
                  (state == S_REQ) || (state == S_WAIT) ||
                  ((state == S_DRAIN) && mem_req_vld);
      mem_enb   = !mem_stall;
      mem_kill  = mem_flush || ((state == S_DONE) && to_flag);
   end

endmodule

// File: tb/tb_core_mem_ctrl.sv
// tb_core_mem_ctrl: directed bench for core_mem_ctrl (TIMEOUT = 8).
// Inputs change 1 time unit after a rising edge; outputs are checked 1 unit
// after that, well away from the next edge.
module tb_core_mem_ctrl;

   logic        clk;
   logic        rst_n;
   logic        mem_req_vld;
   logic        mem_req_we;
   logic [31:0] mem_req_addr;
   logic [31:0] mem_req_wdata;
   logic [3:0]  mem_req_be;
   logic [31:0] mem_cash_base;
   logic        mem_flush;
   logic        l1d_req_vld;
   logic        l1d_req_rdy;
   logic        l1d_req_we;
   logic [31:0] l1d_req_addr;
   logic [31:0] l1d_req_wdata;
   logic [3:0]  l1d_req_be;
   logic        l1d_req_cash;
   logic        l1d_ack_vld;
   logic [31:0] l1d_ack_data;
   logic        mem_stall;
   logic        mem_enb;
   logic        mem_kill;
   logic [31:0] mem_rdata;
   logic        mem_err;

   int checks = 0;
   int errors = 0;

   core_mem_ctrl #(.TIMEOUT(8), .CNT_W(16)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .mem_req_vld   (mem_req_vld),
      .mem_req_we    (mem_req_we),
      .mem_req_addr  (mem_req_addr),
      .mem_req_wdata (mem_req_wdata),
      .mem_req_be    (mem_req_be),
      .mem_cash_base (mem_cash_base),
      .mem_flush     (mem_flush),
      .l1d_req_vld   (l1d_req_vld),
      .l1d_req_rdy   (l1d_req_rdy),
      .l1d_req_we    (l1d_req_we),
      .l1d_req_addr  (l1d_req_addr),
      .l1d_req_wdata (l1d_req_wdata),
      .l1d_req_be    (l1d_req_be),
      .l1d_req_cash  (l1d_req_cash),
      .l1d_ack_vld   (l1d_ack_vld),
      .l1d_ack_data  (l1d_ack_data),
      .mem_stall     (mem_stall),
      .mem_enb       (mem_enb),
      .mem_kill      (mem_kill),
      .mem_rdata     (mem_rdata),
      .mem_err       (mem_err)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; mem_req_vld = 1'b0; mem_req_we = 1'b0; mem_req_addr = '0;
      mem_req_wdata = '0; mem_req_be = '0; mem_cash_base = '0; mem_flush = 1'b0;
      l1d_req_rdy = 1'b0; l1d_ack_vld = 1'b0; l1d_ack_data = '0;
      #2;
      checks++; if (l1d_req_vld !== 1'b0) begin errors++; $display("FAIL rst_vld got %b exp 0", l1d_req_vld); end
      checks++; if (l1d_req_addr !== 32'h0) begin errors++; $display("FAIL rst_addr got %h exp 0", l1d_req_addr); end
      checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL rst_stall got %b exp 0", mem_stall); end
      checks++; if (mem_enb !== 1'b1) begin errors++; $display("FAIL rst_enb got %b exp 1", mem_enb); end
      checks++; if (mem_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h exp 0", mem_rdata); end
      checks++; if ({mem_err, mem_kill} !== 2'b00) begin errors++; $display("FAIL rst_err_kill got %b exp 00", {mem_err, mem_kill}); end
      step();
      rst_n = 1'b1;
      step();
   endtask

   // Cacheable load with rdy=1 and ack one cycle after acceptance.
   task automatic test_load();
      int stall_cycles;
      stall_cycles = 0;
      mem_cash_base = 32'h0000_1000; mem_req_addr = 32'h0000_2000; mem_req_we = 1'b0;
      mem_req_be = 4'hF; mem_req_wdata = '0; l1d_req_rdy = 1'b1; mem_req_vld = 1'b1;
      #1;
      if (mem_stall) stall_cycles++;
      step(); // REQ
      checks++; if (l1d_req_vld !== 1'b1) begin errors++; $display("FAIL load_vld got %b exp 1", l1d_req_vld); end
      checks++; if (l1d_req_cash !== 1'b1) begin errors++; $display("FAIL load_cash got %b exp 1", l1d_req_cash); end
      checks++; if (l1d_req_addr !== 32'h2000) begin errors++; $display("FAIL load_addr got %h exp 2000", l1d_req_addr); end
      checks++; if (l1d_req_we !== 1'b0) begin errors++; $display("FAIL load_we got %b exp 0", l1d_req_we); end
      if (mem_stall) stall_cycles++;
      step(); // WAIT
      l1d_ack_vld = 1'b1; l1d_ack_data = 32'hDEAD_BEEF;
      #1;
      checks++; if (l1d_req_vld !== 1'b0) begin errors++; $display("FAIL load_vld_drop got %b exp 0", l1d_req_vld); end
      if (mem_stall) stall_cycles++;
      step(); // DONE
      l1d_ack_vld = 1'b0;
      #1;
      if (mem_stall) stall_cycles++;
      checks++; if (mem_enb !== 1'b1) begin errors++; $display("FAIL load_enb got %b exp 1", mem_enb); end
      checks++; if (mem_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL load_rdata got %h exp deadbeef", mem_rdata); end
      checks++; if ({mem_err, mem_kill} !== 2'b00) begin errors++; $display("FAIL load_err_kill got %b exp 00", {mem_err, mem_kill}); end
      step(); // IDLE
      mem_req_vld = 1'b0;
      #1;
      if (mem_stall) stall_cycles++;
      checks++; if (stall_cycles !== 3) begin errors++; $display("FAIL load_stall_len got %0d exp 3", stall_cycles); end
   endtask

   // Uncacheable store at the boundary address with rdy low for 4 vld cycles.
   task automatic test_store();
      mem_cash_base = 32'h0000_1000; mem_req_addr = 32'h0000_1000; mem_req_we = 1'b1;
      mem_req_be = 4'b0011; mem_req_wdata = 32'hA5A5_0F0F; l1d_req_rdy = 1'b0; mem_req_vld = 1'b1;
      #1;
      checks++; if (mem_stall !== 1'b1) begin errors++; $display("FAIL st_stall0 got %b exp 1", mem_stall); end
      for (int i = 0; i < 5; i++) begin
         step();
         if (i == 0) begin
            // Disturb the stage inputs: the issued payload must not follow them.
            mem_req_addr = 32'hFFFF_FFF0; mem_req_wdata = '0; mem_req_be = 4'hF; mem_req_we = 1'b0;
         end
         if (i == 4) l1d_req_rdy = 1'b1;
         #1;
         checks++; if (l1d_req_vld !== 1'b1) begin errors++; $display("FAIL st_vld[%0d] got %b exp 1", i, l1d_req_vld); end
         checks++; if (l1d_req_cash !== 1'b0) begin errors++; $display("FAIL st_cash[%0d] got %b exp 0", i, l1d_req_cash); end
         checks++; if (l1d_req_addr !== 32'h1000) begin errors++; $display("FAIL st_addr[%0d] got %h exp 1000", i, l1d_req_addr); end
         checks++; if (l1d_req_wdata !== 32'hA5A5_0F0F) begin errors++; $display("FAIL st_wdata[%0d] got %h exp a5a50f0f", i, l1d_req_wdata); end
         checks++; if (l1d_req_be !== 4'b0011) begin errors++; $display("FAIL st_be[%0d] got %b exp 0011", i, l1d_req_be); end
         checks++; if (l1d_req_we !== 1'b1) begin errors++; $display("FAIL st_we[%0d] got %b exp 1", i, l1d_req_we); end
      end
      step(); // WAIT
      l1d_req_rdy = 1'b0; l1d_ack_vld = 1'b1; l1d_ack_data = 32'h5555_5555;
      #1;
      checks++; if (l1d_req_vld !== 1'b0) begin errors++; $display("FAIL st_vld_drop got %b exp 0", l1d_req_vld); end
      step(); // DONE
      l1d_ack_vld = 1'b0;
      #1;
      checks++; if (mem_enb !== 1'b1) begin errors++; $display("FAIL st_enb got %b exp 1", mem_enb); end
      checks++; if (mem_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL st_rdata got %h exp deadbeef", mem_rdata); end
      step();
      mem_req_vld = 1'b0;
      #1;
   endtask

   // Flush while the request is still waiting for rdy, then flush in IDLE.
   task automatic test_flush_req();
      mem_req_addr = 32'h0000_3000; mem_req_we = 1'b0; l1d_req_rdy = 1'b0; mem_req_vld = 1'b1;
      #1;
      step(); // REQ, 1st vld
      checks++; if (l1d_req_vld !== 1'b1) begin errors++; $display("FAIL fr_vld got %b exp 1", l1d_req_vld); end
      step(); // REQ, 2nd vld
      mem_flush = 1'b1;
      #1;
      checks++; if (mem_kill !== 1'b1) begin errors++; $display("FAIL fr_kill got %b exp 1", mem_kill); end
      checks++; if (mem_stall !== 1'b1) begin errors++; $display("FAIL fr_stall got %b exp 1", mem_stall); end
      step(); // IDLE
      mem_flush = 1'b0; mem_req_vld = 1'b0;
      #1;
      checks++; if (l1d_req_vld !== 1'b0) begin errors++; $display("FAIL fr_vld_drop got %b exp 0", l1d_req_vld); end
      checks++; if ({mem_stall, mem_enb, mem_kill} !== 3'b010) begin errors++; $display("FAIL fr_idle_ctl got %b exp 010", {mem_stall, mem_enb, mem_kill}); end
      step();
      l1d_ack_vld = 1'b1; l1d_ack_data = 32'h1111_1111;
      #1;
      step();
      l1d_ack_vld = 1'b0;
      #1;
      checks++; if (mem_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL fr_stray_ack got %h exp deadbeef", mem_rdata); end
      checks++; if (l1d_req_vld !== 1'b0) begin errors++; $display("FAIL fr_no_req got %b exp 0", l1d_req_vld); end
      mem_req_vld = 1'b1; mem_flush = 1'b1;
      #1;
      checks++; if ({mem_kill, mem_stall} !== 2'b10) begin errors++; $display("FAIL fi_kill_stall got %b exp 10", {mem_kill, mem_stall}); end
      step();
      mem_req_vld = 1'b0; mem_flush = 1'b0;
      #1;
      checks++; if (l1d_req_vld !== 1'b0) begin errors++; $display("FAIL fi_no_req got %b exp 0", l1d_req_vld); end
   endtask

   // Flush after acceptance: drain the ack, then issue the next request.
   task automatic test_flush_wait();
      mem_req_addr = 32'h0000_4000; mem_req_we = 1'b0; l1d_req_rdy = 1'b1; mem_req_vld = 1'b1;
      #1;
      step(); // REQ, accepted
      step(); // WAIT
      l1d_req_rdy = 1'b0; mem_flush = 1'b1;
      #1;
      checks++; if ({mem_stall, mem_kill} !== 2'b11) begin errors++; $display("FAIL fw_stall_kill got %b exp 11", {mem_stall, mem_kill}); end
      step(); // DRAIN, new instruction present
      mem_flush = 1'b0; mem_req_addr = 32'h0000_5000;
      #1;
      checks++; if (mem_stall !== 1'b1) begin errors++; $display("FAIL fw_drain_stall got %b exp 1", mem_stall); end
      checks++; if (l1d_req_vld !== 1'b0) begin errors++; $display("FAIL fw_drain_vld got %b exp 0", l1d_req_vld); end
      step(); // DRAIN, stage empty, ack arrives
      mem_req_vld = 1'b0; l1d_ack_vld = 1'b1; l1d_ack_data = 32'hBAD0_BAD0;
      #1;
      checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL fw_drain_nostall got %b exp 0", mem_stall); end
      step(); // IDLE
      l1d_ack_vld = 1'b0; mem_req_vld = 1'b1;
      #1;
      checks++; if (mem_stall !== 1'b1) begin errors++; $display("FAIL fw_idle_stall got %b exp 1", mem_stall); end
      checks++; if (mem_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL fw_discard got %h exp deadbeef", mem_rdata); end
      step(); // REQ for the new access
      l1d_req_rdy = 1'b1;
      #1;
      checks++; if (l1d_req_vld !== 1'b1) begin errors++; $display("FAIL fw_new_vld got %b exp 1", l1d_req_vld); end
      checks++; if (l1d_req_addr !== 32'h5000) begin errors++; $display("FAIL fw_new_addr got %h exp 5000", l1d_req_addr); end
      step(); // WAIT
      l1d_req_rdy = 1'b0; l1d_ack_vld = 1'b1; l1d_ack_data = 32'h0BAD_F00D;
      #1;
      step(); // DONE
      l1d_ack_vld = 1'b0;
      #1;
      checks++; if (mem_rdata !== 32'h0BAD_F00D) begin errors++; $display("FAIL fw_new_rdata got %h exp 0badf00d", mem_rdata); end
      checks++; if ({mem_enb, mem_kill} !== 2'b10) begin errors++; $display("FAIL fw_done_ctl got %b exp 10", {mem_enb, mem_kill}); end
      step();
      mem_req_vld = 1'b0;
      #1;
   endtask

   // No ack: 8 WAIT cycles, then a single error pulse with kill in DONE.
   task automatic test_timeout();
      mem_req_addr = 32'h0000_7000; mem_req_we = 1'b0; l1d_req_rdy = 1'b1; mem_req_vld = 1'b1;
      #1;
      step(); // REQ, accepted
      step(); // first WAIT cycle
      l1d_req_rdy = 1'b0;
      #1;
      for (int i = 0; i < 8; i++) begin
         if (i != 0) step();
         checks++; if ({mem_err, mem_stall} !== 2'b01) begin errors++; $display("FAIL to_wait[%0d] err_stall got %b exp 01", i, {mem_err, mem_stall}); end
      end
      step(); // DONE
      checks++; if (mem_err !== 1'b1) begin errors++; $display("FAIL to_err got %b exp 1", mem_err); end
      checks++; if ({mem_kill, mem_enb} !== 2'b11) begin errors++; $display("FAIL to_kill_enb got %b exp 11", {mem_kill, mem_enb}); end
      step(); // IDLE
      mem_req_vld = 1'b0;
      #1;
      checks++; if ({mem_err, mem_kill, mem_stall} !== 3'b000) begin errors++; $display("FAIL to_after got %b exp 000", {mem_err, mem_kill, mem_stall}); end
   endtask

   // Asynchronous reset in the middle of WAIT, then a late ack.
   task automatic test_reset_wait();
      mem_req_addr = 32'h0000_6000; mem_req_we = 1'b0; l1d_req_rdy = 1'b1; mem_req_vld = 1'b1;
      #1;
      step(); // REQ
      step(); // WAIT
      l1d_req_rdy = 1'b0;
      #2;
      rst_n = 1'b0; mem_req_vld = 1'b0;
      #1;
      checks++; if (l1d_req_vld !== 1'b0) begin errors++; $display("FAIL rw_vld got %b exp 0", l1d_req_vld); end
      checks++; if (l1d_req_addr !== 32'h0) begin errors++; $display("FAIL rw_addr got %h exp 0", l1d_req_addr); end
      checks++; if (mem_rdata !== 32'h0) begin errors++; $display("FAIL rw_rdata got %h exp 0", mem_rdata); end
      checks++; if ({mem_stall, mem_enb, mem_kill, mem_err} !== 4'b0100) begin errors++; $display("FAIL rw_ctl got %b exp 0100", {mem_stall, mem_enb, mem_kill, mem_err}); end
      step();
      rst_n = 1'b1;
      step();
      l1d_ack_vld = 1'b1; l1d_ack_data = 32'hCAFE_F00D;
      #1;
      step();
      l1d_ack_vld = 1'b0;
      #1;
      checks++; if (mem_rdata !== 32'h0) begin errors++; $display("FAIL rw_late_ack got %h exp 0", mem_rdata); end
      checks++; if ({l1d_req_vld, mem_stall, mem_err} !== 3'b000) begin errors++; $display("FAIL rw_idle got %b exp 000", {l1d_req_vld, mem_stall, mem_err}); end
   endtask

   initial begin
      test_reset();
      test_load();
      test_store();
      test_flush_req();
      test_flush_wait();
      test_timeout();
      test_reset_wait();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/core_mem_ctrl.md
Name: core_mem_ctrl

Overview:
- Sequencer for the memory phase of the Selen pipeline.
- Takes the load/store presented by the memory stage and issues one request to the L1 data port, classified cacheable or uncacheable.
- Waits for the request handshake and the acknowledge, stalling the pipeline in the meantime.
- Returns load data and generates the memory stage's enable and kill controls.

Parameters:
- TIMEOUT, 255: maximum cycles in WAIT before the access is aborted. Legal range 1..65535.
- CNT_W, 16: width of the timeout counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- mem_req_vld  in  1  memory stage holds a load/store
- mem_req_we  in  1  1 = store, 0 = load
- mem_req_addr  in  32  byte address
- mem_req_wdata  in  32  store data
- mem_req_be  in  4  byte enables
- mem_cash_base  in  32  cacheable boundary; address > base is cacheable
- mem_flush  in  1  kill the instruction in the memory stage
- l1d_req_vld  out  1  request valid
- l1d_req_rdy  in  1  request accepted
- l1d_req_we  out  1  write
- l1d_req_addr  out  32  address
- l1d_req_wdata  out  32  write data
- l1d_req_be  out  4  byte enables
- l1d_req_cash  out  1  1 = cacheable
- l1d_ack_vld  in  1  response
- l1d_ack_data  in  32  load data
- mem_stall  out  1  hold earlier stages and the memory stage
- mem_enb  out  1  advance the memory-stage register
- mem_kill  out  1  insert a bubble toward writeback
- mem_rdata  out  32  load data, valid while mem_enb
- mem_err  out  1  one-cycle timeout pulse

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all l1d_req_* = 0; mem_rdata=0; mem_err=0; mem_kill=0; counter=0.
  - mem_enb=1 and mem_stall=0 (combinational from IDLE with no request).
- States: IDLE, REQ, WAIT, DONE, DRAIN.
- IDLE:
  - If mem_req_vld and !mem_flush: register addr, wdata, be and we; l1d_req_cash = (mem_req_addr > mem_cash_base), unsigned compare; go to REQ.
  - Registered l1d_req_vld rises on the next cycle.
  - mem_flush in IDLE: no request is issued; mem_kill=1 for that cycle.
- REQ:
  - l1d_req_vld=1; payload is held stable until l1d_req_rdy.
  - On rdy: drop vld the following cycle, clear the counter, go to WAIT.
  - mem_flush before rdy: drop vld, return to IDLE, mem_kill=1. A same-cycle rdy takes priority and the FSM goes to DRAIN.
  - The counter also runs in REQ; at TIMEOUT, abort to DONE with error.
- WAIT:
  - The counter increments each cycle.
  - On l1d_ack_vld: capture l1d_ack_data into mem_rdata (loads only; stores leave it unchanged), go to DONE.
  - When the counter reaches TIMEOUT-1 without ack: set mem_err, go to DONE with kill flagged.
  - mem_flush: go to DRAIN.
- DRAIN:
  - Wait for l1d_ack_vld and discard the data. No new request is accepted.
  - mem_stall=1 if mem_req_vld; otherwise 0.
  - On ack, go to IDLE.
- DONE:
  - mem_stall=0, mem_enb=1 for exactly one cycle, then IDLE.
  - mem_kill=1 in DONE if a timeout occurred or mem_flush is asserted that cycle.
- mem_stall (combinational) = (IDLE & mem_req_vld & !mem_flush) | REQ | WAIT | (DRAIN & mem_req_vld).
- mem_enb = !mem_stall.
- Minimum load latency with rdy=1 and an ack one cycle after acceptance: request seen in cycle 0, vld in cycle 1, WAIT in cycle 2, ack, DONE in cycle 3. The stall therefore lasts 3 cycles.
- Only one access is outstanding at a time. Acks arriving in IDLE, REQ or DONE are ignored.
- mem_err is a registered one-cycle pulse coincident with entry to DONE.
- The counter saturates; it never wraps.

Test Plan:
- Cacheable load: base=0x0000_1000, addr=0x2000, rdy=1, ack one cycle after acceptance with data 0xDEADBEEF → l1d_req_cash=1; mem_stall high for exactly 3 cycles; mem_rdata=0xDEADBEEF while mem_enb=1.
- Uncacheable store: base=0x1000, addr=0x1000 (equal to base), be=4'b0011, rdy held low 4 cycles → l1d_req_cash=0; payload stable for all 4 vld cycles; mem_rdata unchanged.
- Flush in REQ: mem_flush asserted on the 2nd vld cycle with rdy=0 → vld drops next cycle; mem_kill=1; IDLE; no ack expected.
- Flush in WAIT: flush one cycle after acceptance, new mem_req_vld held → FSM in DRAIN; mem_stall=1 until the ack; ack data discarded; new request issued afterwards.
- Timeout: TIMEOUT=8, rdy=1, no ack → mem_err pulses once after 8 WAIT cycles; mem_kill=1 and mem_enb=1 in DONE.
- Async reset asserted mid-WAIT → all outputs reach reset values immediately; a late ack after reset release is ignored.
